// File: rtl/cpu_csr_unit_pkg.sv
// Machine-mode CSR map, interrupt bit positions and cause codes shared by the CSR unit.
package cpu_csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MSI_BIT  = 3;
    localparam int IRQ_MTI_BIT  = 7;
    localparam int IRQ_MEI_BIT  = 11;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    // Counter index: 0 = mcycle, 1 = minstret, 2+n = mhpmcounter(3+n).
    function automatic logic [11:0] counter_lo_addr(input int idx);
        if (idx == 0)      return CSR_MCYCLE;
        else if (idx == 1) return CSR_MINSTRET;
        else               return CSR_MHPMCOUNTER3 + 12'(idx - 2);
    endfunction

    function automatic int counter_inhibit_bit(input int idx);
        if (idx == 0) return 0;
        else          return idx + 1;
    endfunction

endpackage

// File: rtl/cpu_csr_counter.sv
// One COUNTER_W-bit machine counter with inhibit and split 32-bit lo/hi access.
module cpu_csr_counter #(
    parameter int COUNTER_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_event,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi
);

    logic [COUNTER_W-1:0] count_q;
    logic [COUNTER_W-1:0] count_d;

    // A software write to either half takes the place of that cycle's increment.
    always_comb begin
        count_d = count_q;
        if (wr_lo)
            count_d[31:0] = wdata;
        else if (wr_hi)
            count_d[COUNTER_W-1:32] = wdata[COUNTER_W-33:0];
        else if (count_event && !inhibit)
            count_d = count_q + COUNTER_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign rd_lo = count_q[31:0];
    assign rd_hi = 32'(count_q[COUNTER_W-1:32]);

endmodule

// File: rtl/cpu_csr_unit.sv
// Machine-mode CSR unit: trap entry/mret sequencing, interrupt masking, vectored mtvec
// and mcycle/minstret/hpm counters.
module cpu_csr_unit
    import cpu_csr_unit_pkg::*;
#(
    parameter int          COUNTER_W   = 64,
    parameter int          NUM_HPM     = 2,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          VECTORED_EN = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [11:0]                           raddr,
    output logic [31:0]                           rdata,
    output logic                                  rvalid,
    input  logic [11:0]                           waddr,
    input  logic [31:0]                           wdata,
    input  logic                                  wenable,
    input  logic                                  retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                  trap_valid,
    input  logic [31:0]                           trap_cause,
    input  logic [31:0]                           trap_pc,
    input  logic [31:0]                           trap_tval,
    input  logic                                  mret,
    input  logic                                  irq_ext,
    input  logic                                  irq_timer,
    input  logic                                  irq_soft,
    output logic                                  irq_take,
    output logic [31:0]                           irq_cause,
    output logic [31:0]                           trap_vector,
    output logic [31:0]                           mepc_o
);

    localparam int          NUM_CNT     = 2 + NUM_HPM;
    localparam logic [31:0] MTVEC_WMASK = (VECTORED_EN != 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] INH_WMASK   = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mcountinhibit_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mip_q;
    logic [31:0] irq_lines;
    logic [31:0] irq_pending;
    logic [31:0] mtvec_base;
    logic        sw_write;

    // A trapping instruction is flushed, so its CSR write must not land.
    assign sw_write = wenable && !trap_valid;

    always_comb begin
        irq_lines              = '0;
        irq_lines[IRQ_MEI_BIT] = irq_ext;
        irq_lines[IRQ_MTI_BIT] = irq_timer;
        irq_lines[IRQ_MSI_BIT] = irq_soft;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= MTVEC_RESET & 32'hFFFF_FFFC;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mip_q           <= '0;
        end else begin
            mip_q <= irq_lines;
            if (trap_valid) begin
                mepc_q         <= trap_pc & 32'hFFFF_FFFC;
                mcause_q       <= trap_cause;
                mtval_q        <= trap_tval;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else begin
                if (mret) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end else if (sw_write && waddr == CSR_MSTATUS) begin
                    mstatus_mie_q  <= wdata[MSTATUS_MIE];
                    mstatus_mpie_q <= wdata[MSTATUS_MPIE];
                end
                if (sw_write) begin
                    case (waddr)
                        CSR_MIE:           mie_q           <= wdata & MIE_WMASK;
                        CSR_MTVEC:         mtvec_q         <= wdata & MTVEC_WMASK;
                        CSR_MCOUNTINHIBIT: mcountinhibit_q <= wdata & INH_WMASK;
                        CSR_MSCRATCH:      mscratch_q      <= wdata;
                        CSR_MEPC:          mepc_q          <= wdata & 32'hFFFF_FFFC;
                        CSR_MCAUSE:        mcause_q        <= wdata;
                        CSR_MTVAL:         mtval_q         <= wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [NUM_CNT-1:0] cnt_event;
    logic [NUM_CNT-1:0] cnt_inhibit;
    logic [NUM_CNT-1:0] cnt_wr_lo;
    logic [NUM_CNT-1:0] cnt_wr_hi;
    logic [31:0]        cnt_rd_lo [NUM_CNT];
    logic [31:0]        cnt_rd_hi [NUM_CNT];

    always_comb begin
        cnt_event    = '0;
        cnt_inhibit  = '0;
        cnt_wr_lo    = '0;
        cnt_wr_hi    = '0;
        cnt_event[0] = 1'b1;
        cnt_event[1] = retire;
        for (int n = 0; n < NUM_HPM; n++)
            cnt_event[2+n] = hpm_event[n];
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_inhibit[i] = mcountinhibit_q[counter_inhibit_bit(i)];
            cnt_wr_lo[i]   = sw_write && (waddr == counter_lo_addr(i));
            cnt_wr_hi[i]   = sw_write && (waddr == counter_lo_addr(i) + CSR_HI_OFFSET);
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        cpu_csr_counter #(.COUNTER_W(COUNTER_W)) u_counter (
            .clk         (clk),
            .rst_n       (rst_n),
            .count_event (cnt_event[g]),
            .inhibit     (cnt_inhibit[g]),
            .wr_lo       (cnt_wr_lo[g]),
            .wr_hi       (cnt_wr_hi[g]),
            .wdata       (wdata),
            .rd_lo       (cnt_rd_lo[g]),
            .rd_hi       (cnt_rd_hi[g])
        );
    end

    always_comb begin
        rdata  = '0;
        rvalid = 1'b1;
        case (raddr)
            CSR_MSTATUS: begin
                rdata[12:11]        = 2'b11;
                rdata[MSTATUS_MPIE] = mstatus_mpie_q;
                rdata[MSTATUS_MIE]  = mstatus_mie_q;
            end
            CSR_MIE:           rdata = mie_q;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = mcountinhibit_q;
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = mepc_q;
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MIP:           rdata = mip_q;
            default: begin
                rvalid = 1'b0;
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (raddr == counter_lo_addr(i)) begin
                        rvalid = 1'b1;
                        rdata  = cnt_rd_lo[i];
                    end
                    if (raddr == counter_lo_addr(i) + CSR_HI_OFFSET) begin
                        rvalid = 1'b1;
                        rdata  = cnt_rd_hi[i];
                    end
                end
            end
        endcase
    end

    assign irq_pending = mip_q & mie_q;
    assign irq_take    = mstatus_mie_q && (|irq_pending);

    always_comb begin
        irq_cause = '0;
        if (irq_pending[IRQ_MEI_BIT])      irq_cause = CAUSE_MEI;
        else if (irq_pending[IRQ_MSI_BIT]) irq_cause = CAUSE_MSI;
        else if (irq_pending[IRQ_MTI_BIT]) irq_cause = CAUSE_MTI;
    end

    assign mtvec_base  = {mtvec_q[31:2], 2'b00};
    assign trap_vector = ((VECTORED_EN != 0) && mtvec_q[0] && trap_cause[31])
                         ? mtvec_base + {25'b0, trap_cause[4:0], 2'b00}
                         : mtvec_base;
    assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Directed plus randomized bench for cpu_csr_unit against a behavioural CSR model.
module tb_cpu_csr_unit;

    localparam int          COUNTER_W   = 64;
    localparam int          NUM_HPM     = 3;
    localparam logic [31:0] MTVEC_RESET = 32'h0000_0203;
    localparam int          VECTORED_EN = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata;
    logic        rvalid, wenable, retire;
    logic [2:0]  hpm_event;
    logic        trap_valid, mret;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        irq_ext, irq_timer, irq_soft, irq_take;
    logic [31:0] irq_cause, trap_vector, mepc_o;

    cpu_csr_unit #(
        .COUNTER_W(COUNTER_W), .NUM_HPM(NUM_HPM),
        .MTVEC_RESET(MTVEC_RESET), .VECTORED_EN(VECTORED_EN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .waddr(waddr), .wdata(wdata), .wenable(wenable), .retire(retire),
        .hpm_event(hpm_event), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .irq_take(irq_take), .irq_cause(irq_cause), .trap_vector(trap_vector),
        .mepc_o(mepc_o)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit              m_mie_b, m_mpie;
    bit [31:0]       m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh, m_mip;
    longint unsigned m_cnt [5];
    logic [11:0]     cnt_addr [5] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05};
    int              cnt_inh_bit [5] = '{0, 2, 3, 4, 5};
    logic [11:0]     addr_list [26] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                                        12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                        12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84, 12'hB05,
                                        12'hB85, 12'hB01, 12'hB06, 12'h7C0, 12'h301, 12'h321,
                                        12'hB86, 12'h345};

    task automatic model_reset();
        m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_inh = 0; m_mip = 0;
        m_mtvec = MTVEC_RESET & 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit        wr;
        bit        ev;
        bit [31:0] old_inh;
        wr      = wenable && !trap_valid;
        old_inh = m_inh;
        for (int i = 0; i < 5; i++) begin
            ev = (i == 0) ? 1'b1 : (i == 1) ? retire : hpm_event[i-2];
            if (wr && waddr == cnt_addr[i])
                m_cnt[i] = {m_cnt[i][63:32], wdata};
            else if (wr && waddr == cnt_addr[i] + 12'h080)
                m_cnt[i] = {wdata, m_cnt[i][31:0]};
            else if (ev && !old_inh[cnt_inh_bit[i]])
                m_cnt[i] = m_cnt[i] + 1;
        end
        if (trap_valid) begin
            m_mepc   = trap_pc & 32'hFFFF_FFFC;
            m_mcause = trap_cause;
            m_mtval  = trap_tval;
            m_mpie   = m_mie_b;
            m_mie_b  = 0;
        end else begin
            if (mret) begin
                m_mie_b = m_mpie;
                m_mpie  = 1;
            end else if (wr && waddr == 12'h300) begin
                m_mie_b = wdata[3];
                m_mpie  = wdata[7];
            end
            if (wr) begin
                case (waddr)
                    12'h304: m_mie      = wdata & 32'h888;
                    12'h305: m_mtvec    = wdata & 32'hFFFF_FFFD;
                    12'h320: m_inh      = wdata & 32'h3D;
                    12'h340: m_mscratch = wdata;
                    12'h341: m_mepc     = wdata & 32'hFFFF_FFFC;
                    12'h342: m_mcause   = wdata;
                    12'h343: m_mtval    = wdata;
                    default: ;
                endcase
            end
        end
        m_mip = 0;
        m_mip[11] = irq_ext;
        m_mip[7]  = irq_timer;
        m_mip[3]  = irq_soft;
    endtask

    task automatic model_read(input logic [11:0] a, output bit v, output bit [31:0] d);
        v = 1; d = 0;
        case (a)
            12'h300: begin d = 32'h1800; d[7] = m_mpie; d[3] = m_mie_b; end
            12'h304: d = m_mie;
            12'h305: d = m_mtvec;
            12'h320: d = m_inh;
            12'h340: d = m_mscratch;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h343: d = m_mtval;
            12'h344: d = m_mip;
            default: begin
                v = 0;
                for (int i = 0; i < 5; i++) begin
                    if (a == cnt_addr[i])            begin v = 1; d = m_cnt[i][31:0];  end
                    if (a == cnt_addr[i] + 12'h080)  begin v = 1; d = m_cnt[i][63:32]; end
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (rst_n === 1'b1) model_step();

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit        ev_v;
        bit [31:0] ev_d, pend, exp_cause, exp_vec;
        model_read(raddr, ev_v, ev_d);
        check("rvalid", {31'b0, rvalid}, {31'b0, ev_v});
        check("rdata", rdata, ev_d);
        pend = m_mip & m_mie;
        check("irq_take", {31'b0, irq_take}, {31'b0, m_mie_b && (pend != 0)});
        exp_cause = pend[11] ? 32'h8000_000B : pend[3] ? 32'h8000_0003 :
                    pend[7] ? 32'h8000_0007 : 32'h0;
        check("irq_cause", irq_cause, exp_cause);
        exp_vec = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[0] && trap_cause[31]) exp_vec = exp_vec + 4 * trap_cause[4:0];
        check("trap_vector", trap_vector, exp_vec);
        check("mepc_o", mepc_o, m_mepc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [11:0] a);
        raddr = a;
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        wenable = 1; waddr = a; wdata = d;
        step();
        wenable = 0;
    endtask

    initial begin
        rst_n = 0; model_reset();
        raddr = 12'h305; waddr = 0; wdata = 0; wenable = 0; retire = 0; hpm_event = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0;
        irq_ext = 0; irq_timer = 0; irq_soft = 0;
        step(); step();
        peek(12'h305); check("reset_mtvec", rdata, 32'h0000_0200);
        peek(12'h300); check("reset_mstatus", rdata, 32'h0000_1800);
        check("reset_mepc_o", mepc_o, 32'h0);
        check("reset_irq_take", {31'b0, irq_take}, 32'h0);

        rst_n = 1;
        peek(12'hB00); check("mcycle_0", rdata, 32'd0);
        step(); peek(12'hB00); check("mcycle_1", rdata, 32'd1);
        step(); peek(12'hB00); check("mcycle_2", rdata, 32'd2);
        peek(12'h7C0); check("unmapped_rvalid", {31'b0, rvalid}, 32'h0);
        check("unmapped_rdata", rdata, 32'h0);

        csr_write(12'h320, 32'h5);
        retire = 1; step(); step(); step(); retire = 0;
        peek(12'hB00); check("mcycle_frozen", rdata, 32'd3);
        peek(12'hB02); check("minstret_frozen", rdata, 32'd0);
        csr_write(12'h320, 32'h0);
        step();
        peek(12'hB00); check("mcycle_resumed", rdata, 32'd4);
        retire = 1; step(); retire = 0;
        peek(12'hB02); check("minstret_resumed", rdata, 32'd1);
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'hFFFF_FFFF);
        peek(12'hB00); check("mcycle_lo_written", rdata, 32'hFFFF_FFFF);
        peek(12'hB80); check("mcycle_hi_written", rdata, 32'hFFFF_FFFF);
        step();
        peek(12'hB00); check("mcycle_wrap_lo", rdata, 32'h0);
        peek(12'hB80); check("mcycle_wrap_hi", rdata, 32'h0);

        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        irq_ext = 1; #1;
        check("irq_take_latency", {31'b0, irq_take}, 32'h0);
        step();
        check("irq_take_ext", {31'b0, irq_take}, 32'h1);
        check("irq_cause_ext", irq_cause, 32'h8000_000B);
        irq_soft = 1; step();
        check("irq_cause_ext_soft", irq_cause, 32'h8000_000B);
        csr_write(12'h304, 32'h888);
        irq_ext = 0; irq_timer = 1; step(); step();
        check("irq_cause_soft_timer", irq_cause, 32'h8000_0003);
        irq_soft = 0; irq_timer = 0; step();
        check("irq_idle", {31'b0, irq_take}, 32'h0);

        csr_write(12'h305, 32'h103);
        peek(12'h305); check("mtvec_bit1_zero", rdata, 32'h101);
        trap_valid = 1; trap_pc = 32'h1002; trap_cause = 32'h8000_0007; trap_tval = 32'h55;
        wenable = 1; waddr = 12'h340; wdata = 32'hDEAD; #1;
        check("trap_vector_vec", trap_vector, 32'h11C);
        step();
        trap_valid = 0; wenable = 0; trap_cause = 32'h2;
        check("trap_mepc", mepc_o, 32'h1000);
        peek(12'h300); check("trap_mstatus", rdata, 32'h1880);
        peek(12'h340); check("trap_blocks_write", rdata, 32'h0);
        peek(12'h342); check("trap_mcause", rdata, 32'h8000_0007);
        check("trap_vector_sync", trap_vector, 32'h100);
        mret = 1; step(); mret = 0;
        peek(12'h300); check("mret_mstatus", rdata, 32'h1888);
        csr_write(12'h300, 32'h80);
        mret = 1; csr_write(12'h300, 32'h0); mret = 0;
        peek(12'h300); check("mret_beats_write", rdata, 32'h1888);

        csr_write(12'h304, 32'h0);
        hpm_event = 3'b100; step(); step(); step(); hpm_event = 0;
        csr_write(12'h320, 32'h20);
        hpm_event = 3'b100; step(); step(); hpm_event = 0;
        csr_write(12'h320, 32'h0);
        peek(12'hB05); check("hpm5_count", rdata, 32'd3);
        hpm_event = 3'b100; csr_write(12'hB05, 32'h1234); hpm_event = 0;
        peek(12'hB05); check("hpm5_write_exact", rdata, 32'h1234);

        csr_write(12'h340, 32'hCAFE);
        rst_n = 0; model_reset(); #1;
        peek(12'h340); check("midreset_mscratch", rdata, 32'h0);
        step(); rst_n = 1;
        peek(12'h305); check("midreset_mtvec", rdata, 32'h200);

        for (int i = 0; i < 3000; i++) begin
            retire     = 1'($urandom_range(0, 1));
            hpm_event  = 3'($urandom);
            irq_ext    = ($urandom_range(0, 5) == 0);
            irq_timer  = ($urandom_range(0, 5) == 0);
            irq_soft   = ($urandom_range(0, 5) == 0);
            trap_valid = ($urandom_range(0, 15) == 0);
            trap_pc    = $urandom;
            trap_tval  = $urandom;
            trap_cause = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 31)))
                                                     : 32'($urandom_range(0, 15));
            mret       = ($urandom_range(0, 15) == 0);
            wenable    = ($urandom_range(0, 2) == 0);
            waddr      = addr_list[$urandom_range(0, 25)];
            wdata      = $urandom;
            raddr      = addr_list[$urandom_range(0, 25)];
            if (i == 1500) begin
                rst_n = 0; model_reset();
                step(); step();
                rst_n = 1;
            end else begin
                step();
            end
        end
        wenable = 0; trap_valid = 0; mret = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
